// File: rtl/cpu_pkg.sv
// Shared core definitions for the fetch front end: datapath widths, the
// default reset vector and the {pc, instr} entry carried toward decode.
package cpu_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Instruction fetch is word-granular; the low two address bits are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small circular FIFO used twice by the fetch unit: once for fetched
// {pc, instr} entries and once for the PCs of requests still in flight.
// A pop and a flush in the same cycle both take effect: the popped head
// counts as consumed and everything behind it is discarded.
module fetch_buf #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [W-1:0]                 head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop    = pop && (count_q != '0);
   assign do_push   = push && !flush;
   assign head_data = mem_q[rd_q];
   assign count     = count_q;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ptr_inc(wr_q);
         end
         if (do_pop) begin
            rd_d = ptr_inc(rd_q);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // State registers; storage is cleared so an empty buffer reads as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to
// instruction memory, buffers in-order responses and hands {pc, pc+4, instr}
// to decode. A redirect flushes buffered wrong-path entries and arranges
// for responses still in flight to be dropped as they return.
module ifu_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [INSTR_W-1:0]  imem_rsp_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [XLEN-1:0]     out_pc4,
   output logic [INSTR_W-1:0]  out_instr
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = $bits(fetch_entry_t);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     occupancy;
   logic [XLEN-1:0] rsp_pc;
   logic [EW-1:0]   head_bits;
   fetch_entry_t    head_entry;
   fetch_entry_t    push_entry;
   logic            req_fire, out_fire, buf_push;

   assign out_valid = (fifo_count != '0);
   assign out_fire  = out_valid && out_ready;

   // Slots in use after this cycle's pop; a new request needs a free slot
   // so every outstanding response is guaranteed room in the buffer.
   assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(out_fire);

   // Gated by rst_n so the request drops the instant reset asserts.
   assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign buf_push         = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign push_entry.pc    = rsp_pc;
   assign push_entry.instr = imem_rsp_data;

   assign head_entry = fetch_entry_t'(head_bits);
   assign out_pc     = head_entry.pc;
   assign out_pc4    = head_entry.pc + 32'd4;
   assign out_instr  = head_entry.instr;

   // PCs of issued requests, retired one per response; its count is the in-flight total.
   fetch_buf #(.DEPTH(DEPTH), .W(XLEN)) u_pc_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (req_fire),
      .push_data (fetch_pc_q),
      .pop       (imem_rsp_valid),
      .flush     (1'b0),
      .head_data (rsp_pc),
      .count     (outstanding)
   );

   // Fetched instructions waiting for decode.
   fetch_buf #(.DEPTH(DEPTH), .W(EW)) u_instr_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (buf_push),
      .push_data (push_entry),
      .pop       (out_fire),
      .flush     (redirect_valid),
      .head_data (head_bits),
      .count     (fifo_count)
   );

   // Fetch PC advance and wrong-path drop bookkeeping.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = word_align(redirect_pc);
         // Everything still in flight is wrong-path, except a response landing
         // now, which is discarded directly; older pending drops are subsumed.
         drop_d     = outstanding - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
      end
   end

   // Fetch PC and drop counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a 1-cycle instruction memory model, directed
// scenarios that queue the expected request addresses and decode outputs,
// and a monitor that checks every handshake against those queues.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [31:0] out_instr;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_req[$];
   logic [31:0] exp_out[$];

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_pc4        (out_pc4),
      .out_instr      (out_instr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   // 1-cycle memory, cleared by reset so nothing stale returns afterwards.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
      end else begin
         imem_rsp_valid <= imem_req_valid && imem_req_ready;
         imem_rsp_data  <= instr_of(imem_req_addr);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   // Monitor: compare every request and decode handshake against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) begin
               chk("req_unexpected", imem_req_addr, 32'hFFFF_FFFF);
            end else begin
               chk("req_addr", imem_req_addr, exp_req.pop_front());
            end
         end
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
               chk("out_unexpected", out_pc, 32'hFFFF_FFFF);
            end else begin
               logic [31:0] e;
               e = exp_out.pop_front();
               chk("out_pc", out_pc, e);
               chk("out_pc4", out_pc4, e + 32'd4);
               chk("out_instr", out_instr, instr_of(e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, 32'h3000);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_pc4", out_pc4, 32'h4);
      chk("rst_out_instr", out_instr, 0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic push_seq(input logic [31:0] base, input int n, input logic is_req);
      for (int i = 0; i < n; i++) begin
         if (is_req) exp_req.push_back(base + 32'(4 * i));
         else        exp_out.push_back(base + 32'(4 * i));
      end
   endtask

   task automatic stop_phase();
      out_ready      = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      repeat (3) tick();
      chk("req_left", exp_req.size(), 0);
      chk("out_left", exp_out.size(), 0);
      exp_req.delete();
      exp_out.delete();
   endtask

   initial begin
      rst_n          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      #2;

      // Streaming: one request and one delivery per cycle.
      do_reset();
      out_ready = 1'b1; imem_req_ready = 1'b1;
      push_seq(32'h3000, 8, 1'b1);
      push_seq(32'h3000, 6, 1'b0);
      tick();
      chk("first_valid_c0", out_valid, 0);
      tick();
      chk("first_valid_c1", out_valid, 1);
      chk("first_pc", out_pc, 32'h3000);
      chk("first_pc4", out_pc4, 32'h3004);
      repeat (6) begin
         tick();
         chk("stream_no_gap", out_valid, 1);
      end
      stop_phase();

      // Decode backpressure: fetch stops at DEPTH, resumes without loss.
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b0;
      exp_req.push_back(32'h3000); exp_req.push_back(32'h3004);
      push_seq(32'h3008, 3, 1'b1);
      push_seq(32'h3000, 3, 1'b0);
      tick(); tick();
      repeat (4) begin
         tick();
         chk("bp_req_valid", imem_req_valid, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_pc_hold", out_pc, 32'h3000);
      end
      out_ready = 1'b1;
      repeat (3) tick();
      stop_phase();

      // Redirect with one in flight (0x3008) and one buffered (0x3004).
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b1;
      push_seq(32'h3000, 3, 1'b1);
      push_seq(32'h4000, 4, 1'b1);
      exp_out.push_back(32'h3000);
      push_seq(32'h4000, 2, 1'b0);
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_4001; out_ready = 1'b0;
      #1;
      chk("redir_req_blocked", imem_req_valid, 0);
      tick();
      redirect_valid = 1'b0; out_ready = 1'b1;
      chk("redir_flushed", out_valid, 0);
      tick(); tick();
      chk("redir_target_valid", out_valid, 1);
      chk("redir_target_pc", out_pc, 32'h4000);
      tick(); tick();
      stop_phase();

      // Memory stall: request held stable for three cycles.
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b1;
      push_seq(32'h3000, 5, 1'b1);
      push_seq(32'h3000, 3, 1'b0);
      tick();
      imem_req_ready = 1'b0;
      repeat (3) begin
         chk("stall_req_valid", imem_req_valid, 1);
         chk("stall_req_addr", imem_req_addr, 32'h3004);
         tick();
      end
      imem_req_ready = 1'b1;
      repeat (4) tick();
      stop_phase();

      // Redirect coincident with the delivery of 0x3004.
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b1;
      push_seq(32'h3000, 3, 1'b1);
      push_seq(32'h5000, 4, 1'b1);
      push_seq(32'h3000, 2, 1'b0);
      push_seq(32'h5000, 2, 1'b0);
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
      tick();
      redirect_valid = 1'b0;
      chk("redir_pop_once", out_valid, 0);
      repeat (4) tick();
      stop_phase();

      // Asynchronous reset mid-stream, then restart from the reset vector.
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b1;
      push_seq(32'h3000, 5, 1'b1);
      push_seq(32'h3000, 3, 1'b0);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_req_valid", imem_req_valid, 0);
      chk("async_req_left", exp_req.size(), 0);
      chk("async_out_left", exp_out.size(), 0);
      tick();
      do_reset();
      push_seq(32'h3000, 4, 1'b1);
      push_seq(32'h3000, 2, 1'b0);
      repeat (4) tick();
      stop_phase();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
